// File: rtl/lisa_mem_arbiter.sv
// rtl/lisa_mem_arbiter.sv - two-port (fetch / load-store) arbiter onto one single-cycle-latency memory
//
// Purpose:
//   Shares one memory port between a fetch (IF) requester and a load/store (LS)
//   requester. Grants are combinational; read data comes back one cycle after the
//   grant and goes to whichever port owned that read.
//   Optional build macro: LISA_ARB_RR_EN selects round-robin arbitration on
//   contention. When it is undefined, LS always wins contention (fixed priority).
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   if_req/if_addr -> if_gnt          fetch request / grant
//   if_rvalid, if_rdata               fetch read response
//   ls_req/ls_we/ls_addr/ls_wdata     load/store request
//   ls_gnt, ls_rvalid, ls_rdata       load/store grant / read response
//   mem_addr/mem_write_en/mem_write_data, mem_read_data   shared memory port
//   conflict_cnt                      saturating count of cycles with both requests
module lisa_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [15:0]       conflict_cnt
);

    // Owner of the read response that returns in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    localparam logic WIN_IF = 1'b0;
    localparam logic WIN_LS = 1'b1;

    owner_e      owner_q, owner_d;
    logic        last_winner_q, last_winner_d;
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic        contention;
    logic        ls_wins;

    // Grant decision
    always_comb begin
        if_gnt     = 1'b0;
        ls_gnt     = 1'b0;
        contention = if_req & ls_req;
`ifdef LISA_ARB_RR_EN
        // Round-robin: on contention the port that did not win last time goes.
        ls_wins    = (last_winner_q == WIN_IF);
`else
        ls_wins    = 1'b1;
`endif
        if (rst_n) begin
            if (contention) begin
                ls_gnt = ls_wins;
                if_gnt = ~ls_wins;
            end else begin
                if_gnt = if_req;
                ls_gnt = ls_req;
            end
        end
    end

    // Shared memory port: everything is zero unless someone is granted.
    always_comb begin
        mem_addr       = '0;
        mem_write_en   = 1'b0;
        mem_write_data = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_addr       = ls_addr;
            mem_write_en   = ls_we;
            mem_write_data = ls_we ? ls_wdata : '0;
        end
    end

    // Next-state logic
    always_comb begin
        owner_d        = OWN_NONE;
        last_winner_d  = last_winner_q;
        conflict_cnt_d = conflict_cnt_q;
        if (if_gnt) begin
            owner_d       = OWN_IF;
            last_winner_d = WIN_IF;
        end else if (ls_gnt) begin
            // Stores produce no response, so they leave no owner behind.
            owner_d       = ls_we ? OWN_NONE : OWN_LS;
            last_winner_d = WIN_LS;
        end
        if (contention && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q        <= OWN_NONE;
            last_winner_q  <= WIN_IF;
            conflict_cnt_q <= '0;
        end else begin
            owner_q        <= owner_d;
            last_winner_q  <= last_winner_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Read response steering; rdata is held at zero when not valid.
    always_comb begin
        if_rvalid    = (owner_q == OWN_IF);
        ls_rvalid    = (owner_q == OWN_LS);
        if_rdata     = if_rvalid ? mem_read_data : '0;
        ls_rdata     = ls_rvalid ? mem_read_data : '0;
        conflict_cnt = conflict_cnt_q;
    end

endmodule

// File: tb/tb_lisa_mem_arbiter.sv
// tb/tb_lisa_mem_arbiter.sv - self-checking bench for lisa_mem_arbiter
module tb_lisa_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [15:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [15:0] mem_addr;
    logic        mem_write_en;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic [15:0] conflict_cnt;

    lisa_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: who is owed a read response next cycle
    // (0 none, 1 IF, 2 LS), who won the last grant, and the contention count.
    int  m_pend = 0;
    int  m_last = 1;
    int  m_cnt  = 0;
    int  m_win  = 0;

`ifdef LISA_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // Values observed in the most recent cycle, for directed checks.
    logic        o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid, o_we;
    logic [31:0] o_if_rdata, o_ls_rdata, o_wdata;
    logic [15:0] o_addr, o_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner by the arbitration rules: 0 none, 1 IF, 2 LS.
    function automatic int pick_winner();
        if (!rst_n) return 0;
        if (if_req && ls_req) begin
            if (RR) return (m_last == 1) ? 2 : 1;
            return 2;
        end
        if (if_req) return 1;
        if (ls_req) return 2;
        return 0;
    endfunction

    // One clock cycle: called at posedge+1 with inputs already driven.
    task automatic do_cycle();
        int win;
        #3;
        win = pick_winner();
        o_if_gnt = if_gnt;  o_ls_gnt = ls_gnt;
        o_if_rvalid = if_rvalid; o_ls_rvalid = ls_rvalid;
        o_if_rdata = if_rdata;   o_ls_rdata = ls_rdata;
        o_addr = mem_addr; o_we = mem_write_en; o_wdata = mem_write_data; o_cnt = conflict_cnt;
        check("if_gnt", {31'd0, if_gnt}, {31'd0, win == 1});
        check("ls_gnt", {31'd0, ls_gnt}, {31'd0, win == 2});
        check("mem_addr", {16'd0, mem_addr},
              (win == 1) ? {16'd0, if_addr} : (win == 2) ? {16'd0, ls_addr} : 32'd0);
        check("mem_we", {31'd0, mem_write_en}, {31'd0, (win == 2) && ls_we});
        check("mem_wdata", mem_write_data, ((win == 2) && ls_we) ? ls_wdata : 32'd0);
        check("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_pend == 1});
        check("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, m_pend == 2});
        check("if_rdata", if_rdata, (m_pend == 1) ? mem_read_data : 32'd0);
        check("ls_rdata", ls_rdata, (m_pend == 2) ? mem_read_data : 32'd0);
        check("conflict_cnt", {16'd0, conflict_cnt}, m_cnt[31:0]);
        @(posedge clk);
        if (!rst_n) begin
            m_pend = 0; m_last = 1; m_cnt = 0;
        end else begin
            if (if_req && ls_req && m_cnt < 65535) m_cnt++;
            m_pend = (win == 1) ? 1 : ((win == 2) && !ls_we) ? 2 : 0;
            if (win != 0) m_last = win;
        end
        m_win = win;
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        do_cycle();
        do_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        bit hold_if, hold_ls;
        rst_n = 1'b0;
        idle();
        mem_read_data = '0;
        @(posedge clk); #1;
        do_reset();

        // Reset state
        do_cycle();
        check("rst_if_rvalid", {31'd0, o_if_rvalid}, 32'd0);
        check("rst_ls_rvalid", {31'd0, o_ls_rvalid}, 32'd0);
        check("rst_cnt", {16'd0, o_cnt}, 32'd0);

        // Single fetch read
        if_req = 1'b1; if_addr = 16'h0010; mem_read_data = $urandom;
        do_cycle();
        check("f_gnt", {31'd0, o_if_gnt}, 32'd1);
        check("f_addr", {16'd0, o_addr}, 32'h0010);
        idle(); mem_read_data = 32'hDEADBEEF;
        do_cycle();
        check("f_rvalid", {31'd0, o_if_rvalid}, 32'd1);
        check("f_rdata", o_if_rdata, 32'hDEADBEEF);
        check("f_ls_rvalid", {31'd0, o_ls_rvalid}, 32'd0);

        // Store
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0200; ls_wdata = 32'h12345678;
        do_cycle();
        check("st_we", {31'd0, o_we}, 32'd1);
        check("st_addr", {16'd0, o_addr}, 32'h0200);
        check("st_wdata", o_wdata, 32'h12345678);
        idle(); mem_read_data = $urandom;
        do_cycle();
        check("st_no_rvalid", {30'd0, o_if_rvalid, o_ls_rvalid}, 32'd0);

        // Four cycles of contention from a fresh reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if_req = 1'b1; if_addr = 16'h0100; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0300;
            mem_read_data = $urandom;
            do_cycle();
            check("cont_ls_gnt", {31'd0, o_ls_gnt}, RR ? {31'd0, k % 2 == 0} : 32'd1);
            check("cont_if_gnt", {31'd0, o_if_gnt}, RR ? {31'd0, k % 2 == 1} : 32'd0);
        end
        idle();
        do_cycle();
        check("cont_cnt4", {16'd0, o_cnt}, 32'd4);

        // Interleaved reads IF, LS, IF
        for (int k = 0; k < 4; k++) begin
            idle();
            if (k == 0) begin if_req = 1'b1; if_addr = 16'h0001; end
            if (k == 1) begin ls_req = 1'b1; ls_addr = 16'h0002; end
            if (k == 2) begin if_req = 1'b1; if_addr = 16'h0003; end
            mem_read_data = 32'h1111_0000 + k;
            do_cycle();
            if (k == 1 || k == 3) begin
                check("alt_if_rv", {31'd0, o_if_rvalid}, 32'd1);
                check("alt_if_rd", o_if_rdata, 32'h1111_0000 + k);
            end
            if (k == 2) begin
                check("alt_ls_rv", {31'd0, o_ls_rvalid}, 32'd1);
                check("alt_ls_rd", o_ls_rdata, 32'h1111_0002);
            end
        end

        // Reset applied during an LS read request
        if_req = 1'b1; ls_req = 1'b1; ls_addr = 16'h0040; do_cycle();
        idle(); ls_req = 1'b1; ls_addr = 16'h0044; rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1; idle();
        do_cycle();
        check("rstrd_ls_rvalid", {31'd0, o_ls_rvalid}, 32'd0);
        check("rstrd_cnt", {16'd0, o_cnt}, 32'd0);
        if_req = 1'b1; ls_req = 1'b1;
        do_cycle();
        check("rstrd_ls_wins", {31'd0, o_ls_gnt}, 32'd1);

        // Randomized traffic; un-granted requests stay stable.
        idle(); hold_if = 0; hold_ls = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold_if) begin
                if_req = $urandom_range(0, 1); if_addr = $urandom;
            end
            if (!hold_ls) begin
                ls_req = $urandom_range(0, 1); ls_we = $urandom_range(0, 1);
                ls_addr = $urandom; ls_wdata = $urandom;
            end
            rst_n = ($urandom_range(0, 39) != 0);
            mem_read_data = $urandom;
            do_cycle();
            hold_if = if_req && (m_win != 1);
            hold_ls = ls_req && (m_win != 2);
        end
        rst_n = 1'b1;

        // Saturation
        do_reset();
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
        for (int n = 0; n < 32'h10000; n++) begin
            mem_read_data = '0;
            do_cycle();
        end
        idle();
        do_cycle();
        check("sat_cnt", {16'd0, o_cnt}, 32'h0000FFFF);
        do_cycle();
        check("sat_hold", {16'd0, o_cnt}, 32'h0000FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lisa_mem_arbiter.md
LISA_MEM_ARBITER -- requirements
Module: lisa_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, memory word-address width; DATA_W, 32, data width.
REQ-002 Ports SHALL be, in order:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- if_req  input  1  fetch port read request.
- if_addr  input  ADDR_W  fetch address.
- if_gnt  output  1  fetch request accepted this cycle.
- if_rvalid  output  1  fetch read data valid.
- if_rdata  output  DATA_W  fetch read data.
- ls_req  input  1  load/store port request.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  load/store address.
- ls_wdata  input  DATA_W  store data.
- ls_gnt  output  1  load/store request accepted this cycle.
- ls_rvalid  output  1  load data valid.
- ls_rdata  output  DATA_W  load data.
- mem_addr  output  ADDR_W  shared memory address.
- mem_write_en  output  1  shared memory write strobe.
- mem_write_data  output  DATA_W  shared memory write data.
- mem_read_data  input  DATA_W  memory read data, valid one cycle after address.
- conflict_cnt  output  16  saturating count of contention cycles.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.

Function
REQ-004 if_gnt, ls_gnt SHALL be combinational from the current-cycle requests and arbiter state; at most one SHALL be 1 in any cycle.
REQ-005 With exactly one requester asserting req, that requester SHALL be granted in the same cycle.
REQ-006 With no grant, mem_addr, mem_write_data SHALL be 0 and mem_write_en SHALL be 0.
REQ-007 On a grant, mem_addr SHALL carry the winner's address; mem_write_en SHALL equal ls_gnt & ls_we; mem_write_data SHALL equal ls_wdata when ls_gnt & ls_we, else 0.
REQ-008 A read grant in cycle N SHALL assert the winner's rvalid for exactly cycle N+1, with that port's rdata = mem_read_data in N+1.
REQ-009 A store grant SHALL produce no rvalid.
REQ-010 rdata of a port SHALL be 0 whenever its rvalid is 0.
REQ-011 Grants SHALL be issuable every cycle; back-to-back reads SHALL return in issue order, one per cycle, each tagged to its owner.
REQ-012 A requester SHALL hold req, addr, we, wdata stable until granted; un-granted requests SHALL have no side effects.
REQ-013 conflict_cnt SHALL increment by 1 on each cycle with if_req & ls_req, saturating at 0xFFFF.
REQ-014 Arbiter state SHALL be: owner register (none/IF/LS) for the pending read response, and last_winner bit (IF/LS) updated on every grant.

Reset
REQ-015 While rst_n = 0 at a clock edge: if_rvalid, ls_rvalid = 0; owner = none; last_winner = IF; conflict_cnt = 0.
REQ-016 A read granted in the cycle reset is applied SHALL produce no rvalid afterwards.
REQ-017 Grants and mem_* outputs SHALL be forced to 0 while rst_n = 0.

Configuration
REQ-018 With LISA_ARB_RR_EN defined, contention SHALL grant the port that is not last_winner (round-robin).
REQ-019 Without LISA_ARB_RR_EN, contention SHALL always grant LS (fixed priority); last_winner still updates but does not affect arbitration.

Verification
REQ-020 Single IF read addr 0x0010, mem returns 0xDEADBEEF -> if_gnt same cycle, if_rvalid next cycle with if_rdata 0xDEADBEEF, ls_rvalid 0.
REQ-021 LS store addr 0x0200 data 0x12345678 -> mem_write_en 1, mem_addr 0x0200, mem_write_data 0x12345678 that cycle; no rvalid next cycle.
REQ-022 Both req held 4 cycles, RR build -> grants LS, IF, LS, IF; fixed build -> LS ×4, IF waits; conflict_cnt = 4.
REQ-023 Alternating reads IF 0x0001, LS 0x0002, IF 0x0003 in consecutive cycles -> rvalid sequence IF, LS, IF with matching mem_read_data.
REQ-024 rst_n low in the cycle of an LS read grant -> ls_rvalid 0 next cycle, conflict_cnt 0, next contention in RR build grants LS.
REQ-025 Force 0x10000 contention cycles -> conflict_cnt holds 0xFFFF, no wrap.
